// File: rtl/usb_cmd_frame_parser_pkg.sv
// Shared definitions for the USB CDC command-frame parser and its dispatcher:
// header bytes, parser state encoding, error codes and the payload beat layout.
package usb_cmd_frame_parser_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LEN_W  = 16;

  localparam logic [BYTE_W-1:0] FRAME_HDR0 = 8'hAA;
  localparam logic [BYTE_W-1:0] FRAME_HDR1 = 8'h55;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR2    = 3'd1,
    ST_CMD     = 3'd2,
    ST_LEN_H   = 3'd3,
    ST_LEN_L   = 3'd4,
    ST_PAYLOAD = 3'd5,
    ST_CHK     = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_CHECKSUM = 2'b01,
    ERR_LENGTH   = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } err_e;

  typedef struct packed {
    logic [BYTE_W-1:0] data;
    logic [LEN_W-1:0]  index;
  } payload_beat_t;

  // Frame checksum is a plain modulo-256 byte sum.
  function automatic logic [BYTE_W-1:0] chk_add(input logic [BYTE_W-1:0] acc,
                                                input logic [BYTE_W-1:0] b);
    return BYTE_W'(acc + b);
  endfunction

endpackage

// File: rtl/usb_cmd_frame_parser.sv
// Byte-stream command-frame parser: AA 55 | CMD | LEN_H | LEN_L | PAYLOAD | CHK.
// Streams payload with index and reports commit (cmd_done) or abort (cmd_error).
module usb_cmd_frame_parser
  import usb_cmd_frame_parser_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD    = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 600000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  usb_data_in,
  input  logic        usb_data_valid_in,
  output logic        cmd_start,
  output logic [7:0]  cmd_type,
  output logic [15:0] cmd_length,
  output logic [7:0]  payload_data,
  output logic        payload_valid,
  output logic [15:0] payload_index,
  output logic        cmd_done,
  output logic        cmd_error,
  output logic [1:0]  error_code,
  output logic        frame_busy
);

  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PAYLOAD);

  state_e              state_q, state_d;
  logic [BYTE_W-1:0]   sum_q, sum_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [BYTE_W-1:0]   cmd_q, cmd_d;
  logic [BYTE_W-1:0]   len_h_q, len_h_d;
  logic [TO_W-1:0]     to_q, to_d;
  payload_beat_t       payload_q, payload_d;

  logic                cmd_start_d, payload_valid_d, cmd_done_d, cmd_error_d, frame_busy_d;
  logic [7:0]          cmd_type_d;
  logic [15:0]         cmd_length_d;
  logic [1:0]          error_code_d;

  logic [LEN_W-1:0]    len_rx;
  logic                len_bad;
  logic                last_payload;
  logic                timeout_hit;
  logic                byte_take;

  assign len_rx       = {len_h_q, usb_data_in};
  assign len_bad      = (len_rx > MAX_LEN);
  assign last_payload = (cnt_q == (len_q - LEN_W'(1)));
  // An arriving byte in the expiry cycle pre-empts the timeout.
  assign timeout_hit  = (state_q != ST_IDLE) && !usb_data_valid_in && (to_q == TO_LAST);
  assign byte_take    = usb_data_valid_in && !timeout_hit;

  assign payload_data  = payload_q.data;
  assign payload_index = payload_q.index;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (timeout_hit) begin
      state_d = ST_IDLE;
    end else if (byte_take) begin
      case (state_q)
        ST_IDLE: begin
          if (usb_data_in == FRAME_HDR0) state_d = ST_HDR2;
        end
        ST_HDR2: begin
          if (usb_data_in == FRAME_HDR1) begin
            state_d = ST_CMD;
          end else if (usb_data_in != FRAME_HDR0) begin
            state_d = ST_IDLE;
          end
        end
        ST_CMD:   state_d = ST_LEN_H;
        ST_LEN_H: state_d = ST_LEN_L;
        ST_LEN_L: begin
          if (len_bad) begin
            state_d = ST_IDLE;
          end else if (len_rx == '0) begin
            state_d = ST_CHK;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (last_payload) state_d = ST_CHK;
        end
        ST_CHK:  state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output and datapath next values
  always_comb begin
    cmd_start_d     = 1'b0;
    payload_valid_d = 1'b0;
    cmd_done_d      = 1'b0;
    cmd_error_d     = 1'b0;
    cmd_type_d      = cmd_type;
    cmd_length_d    = cmd_length;
    error_code_d    = error_code;
    payload_d       = payload_q;
    sum_d           = sum_q;
    cnt_d           = cnt_q;
    len_d           = len_q;
    cmd_d           = cmd_q;
    len_h_d         = len_h_q;
    frame_busy_d    = (state_d != ST_IDLE);

    if ((state_q == ST_IDLE) || usb_data_valid_in || timeout_hit) begin
      to_d = '0;
    end else begin
      to_d = to_q + TO_W'(1);
    end

    // A stalled HDR2 is not yet a frame, so it drops silently.
    if (timeout_hit && (state_q != ST_HDR2)) begin
      cmd_error_d  = 1'b1;
      error_code_d = ERR_TIMEOUT;
    end

    if (byte_take) begin
      case (state_q)
        ST_CMD: begin
          cmd_d = usb_data_in;
          sum_d = usb_data_in;
        end
        ST_LEN_H: begin
          len_h_d = usb_data_in;
          sum_d   = chk_add(sum_q, usb_data_in);
        end
        ST_LEN_L: begin
          len_d = len_rx;
          sum_d = chk_add(sum_q, usb_data_in);
          cnt_d = '0;
          if (len_bad) begin
            cmd_error_d  = 1'b1;
            error_code_d = ERR_LENGTH;
          end else begin
            cmd_start_d  = 1'b1;
            cmd_type_d   = cmd_q;
            cmd_length_d = len_rx;
          end
        end
        ST_PAYLOAD: begin
          payload_valid_d = 1'b1;
          payload_d.data  = usb_data_in;
          payload_d.index = cnt_q;
          sum_d           = chk_add(sum_q, usb_data_in);
          cnt_d           = last_payload ? '0 : (cnt_q + LEN_W'(1));
        end
        ST_CHK: begin
          if (usb_data_in == sum_q) begin
            cmd_done_d = 1'b1;
          end else begin
            cmd_error_d  = 1'b1;
            error_code_d = ERR_CHECKSUM;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q         <= '0;
      cnt_q         <= '0;
      len_q         <= '0;
      cmd_q         <= '0;
      len_h_q       <= '0;
      to_q          <= '0;
      payload_q     <= '0;
      cmd_start     <= 1'b0;
      cmd_type      <= '0;
      cmd_length    <= '0;
      payload_valid <= 1'b0;
      cmd_done      <= 1'b0;
      cmd_error     <= 1'b0;
      error_code    <= '0;
      frame_busy    <= 1'b0;
    end else begin
      sum_q         <= sum_d;
      cnt_q         <= cnt_d;
      len_q         <= len_d;
      cmd_q         <= cmd_d;
      len_h_q       <= len_h_d;
      to_q          <= to_d;
      payload_q     <= payload_d;
      cmd_start     <= cmd_start_d;
      cmd_type      <= cmd_type_d;
      cmd_length    <= cmd_length_d;
      payload_valid <= payload_valid_d;
      cmd_done      <= cmd_done_d;
      cmd_error     <= cmd_error_d;
      error_code    <= error_code_d;
      frame_busy    <= frame_busy_d;
    end
  end

endmodule

// File: tb/tb_usb_cmd_frame_parser.sv
// Bench for usb_cmd_frame_parser: frames are built at transaction level, their
// expected output events are scheduled per clock edge and checked every cycle.
module tb_usb_cmd_frame_parser;

  localparam int MAXP = 1024;
  localparam int TOUT = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  usb_data_in = 8'h00;
  logic        usb_data_valid_in = 1'b0;
  logic        cmd_start;
  logic [7:0]  cmd_type;
  logic [15:0] cmd_length;
  logic [7:0]  payload_data;
  logic        payload_valid;
  logic [15:0] payload_index;
  logic        cmd_done;
  logic        cmd_error;
  logic [1:0]  error_code;
  logic        frame_busy;

  always #5 clk = ~clk;

  usb_cmd_frame_parser #(.MAX_PAYLOAD(MAXP), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk               (clk),
    .rst               (rst),
    .usb_data_in       (usb_data_in),
    .usb_data_valid_in (usb_data_valid_in),
    .cmd_start         (cmd_start),
    .cmd_type          (cmd_type),
    .cmd_length        (cmd_length),
    .payload_data      (payload_data),
    .payload_valid     (payload_valid),
    .payload_index     (payload_index),
    .cmd_done          (cmd_done),
    .cmd_error         (cmd_error),
    .error_code        (error_code),
    .frame_busy        (frame_busy)
  );

  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  // Expected outputs right after a given clock edge.
  typedef struct packed {
    logic        start;
    logic        pv;
    logic        done;
    logic        err;
    logic        busy_chg;
    logic        busy;
    logic [7:0]  pdata;
    logic [15:0] pidx;
    logic [7:0]  typ;
    logic [15:0] len;
    logic [1:0]  code;
  } ev_t;

  ev_t         evq [int];
  logic [7:0]  m_type = '0;
  logic [15:0] m_len  = '0;
  logic [1:0]  m_code = '0;
  logic        m_busy = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  pl [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, ecnt, act, exp);
    end
  endtask

  function automatic ev_t ev_get(input int t);
    if (evq.exists(t)) return evq[t];
    return '0;
  endfunction

  task automatic exp_busy(input int t, input logic b);
    ev_t e = ev_get(t);
    e.busy_chg = 1'b1; e.busy = b; evq[t] = e;
  endtask

  task automatic exp_start(input int t, input logic [7:0] typ, input logic [15:0] len);
    ev_t e = ev_get(t);
    e.start = 1'b1; e.typ = typ; e.len = len; evq[t] = e;
  endtask

  task automatic exp_pv(input int t, input logic [7:0] d, input logic [15:0] idx);
    ev_t e = ev_get(t);
    e.pv = 1'b1; e.pdata = d; e.pidx = idx; evq[t] = e;
  endtask

  task automatic exp_done(input int t);
    ev_t e = ev_get(t);
    e.done = 1'b1; evq[t] = e;
  endtask

  task automatic exp_err(input int t, input logic [1:0] code);
    ev_t e = ev_get(t);
    e.err = 1'b1; e.code = code; evq[t] = e;
  endtask

  // Per-cycle compare against the scheduled expectations.
  always @(negedge clk) begin
    ev_t e;
    if (rst) begin
      m_type = '0; m_len = '0; m_code = '0; m_busy = 1'b0;
      chk("rst_cmd_start",     32'(cmd_start),     32'd0);
      chk("rst_payload_valid", 32'(payload_valid), 32'd0);
      chk("rst_payload_data",  32'(payload_data),  32'd0);
      chk("rst_payload_index", 32'(payload_index), 32'd0);
      chk("rst_cmd_done",      32'(cmd_done),      32'd0);
      chk("rst_cmd_error",     32'(cmd_error),     32'd0);
      chk("rst_cmd_type",      32'(cmd_type),      32'd0);
      chk("rst_cmd_length",    32'(cmd_length),    32'd0);
      chk("rst_error_code",    32'(error_code),    32'd0);
      chk("rst_frame_busy",    32'(frame_busy),    32'd0);
    end else begin
      e = ev_get(ecnt);
      if (evq.exists(ecnt)) evq.delete(ecnt);
      if (e.start) begin m_type = e.typ; m_len = e.len; end
      if (e.err) m_code = e.code;
      if (e.busy_chg) m_busy = e.busy;
      chk("cmd_start",     32'(cmd_start),     32'(e.start));
      chk("payload_valid", 32'(payload_valid), 32'(e.pv));
      if (e.pv) begin
        chk("payload_data",  32'(payload_data),  32'(e.pdata));
        chk("payload_index", 32'(payload_index), 32'(e.pidx));
      end
      chk("cmd_done",   32'(cmd_done),   32'(e.done));
      chk("cmd_error",  32'(cmd_error),  32'(e.err));
      chk("cmd_type",   32'(cmd_type),   32'(m_type));
      chk("cmd_length", 32'(cmd_length), 32'(m_len));
      chk("error_code", 32'(error_code), 32'(m_code));
      chk("frame_busy", 32'(frame_busy), 32'(m_busy));
    end
  end

  task automatic tick();
    usb_data_valid_in = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drive one byte; tag is the edge at which the DUT samples it.
  task automatic put(input logic [7:0] b, output int tag);
    usb_data_in       = b;
    usb_data_valid_in = 1'b1;
    tag               = ecnt + 1;
    @(posedge clk);
    #1;
    usb_data_valid_in = 1'b0;
  endtask

  function automatic int pick_gap(input int mode);
    if (mode == 0) return 1;
    if (mode < 0)  return -mode;
    if ($urandom_range(0, 4) == 0) return int'($urandom_range(1, mode));
    return 1;
  endfunction

  task automatic fill_payload(input int len);
    pl.delete();
    for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
  endtask

  // Send one frame (payload from pl) and schedule what it must produce.
  task automatic send_frame(input logic [7:0] cmd, input int len, input logic [7:0] chk_xor,
                            input int trunc, input int gap_mode, input bit allow_timeout);
    logic [7:0]  b [$];
    logic [7:0]  sum;
    logic [15:0] l16;
    int          ntot, n, t, g;
    l16 = 16'(len);
    b.push_back(8'hAA);
    b.push_back(8'h55);
    b.push_back(cmd);
    b.push_back(l16[15:8]);
    b.push_back(l16[7:0]);
    if (len <= MAXP) begin
      sum = cmd + l16[15:8] + l16[7:0];
      for (int i = 0; i < len; i++) begin
        b.push_back(pl[i]);
        sum = sum + pl[i];
      end
      b.push_back(sum ^ chk_xor);
    end
    ntot = b.size();
    n    = (trunc < 0 || trunc > ntot) ? ntot : trunc;
    t    = ecnt;
    for (int i = 0; i < n; i++) begin
      g = (i == 0) ? 1 : pick_gap(gap_mode);
      idle(g - 1);
      put(b[i], t);
      if (i == 0) begin
        exp_busy(t, 1'b1);
      end else if (i == 4) begin
        if (len > MAXP) begin
          exp_err(t, 2'b10);
          exp_busy(t, 1'b0);
        end else begin
          exp_start(t, cmd, l16);
        end
      end else if (i >= 5 && i < 5 + len) begin
        exp_pv(t, b[i], 16'(i - 5));
      end else if (i == 5 + len) begin
        if (chk_xor == 8'h00) exp_done(t);
        else                  exp_err(t, 2'b01);
        exp_busy(t, 1'b0);
      end
    end
    if (n < ntot && allow_timeout) begin
      if (n > 1) exp_err(t + TOUT, 2'b11);
      exp_busy(t + TOUT, 1'b0);
      idle(TOUT + 2);
    end
  endtask

  initial begin
    int t, r, len, trunc, gm;
    logic [7:0] x, xr;

    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy",  32'(frame_busy), 32'd0);
    chk("reset_type",  32'(cmd_type),   32'd0);
    rst = 1'b0;
    tick();

    // AA 55 01 00 02 10 20 33: good two-byte frame
    pl = '{8'h10, 8'h20};
    send_frame(8'h01, 2, 8'h00, -1, 0, 1'b1);
    chk("t1_done",   32'(cmd_done),   32'd1);
    chk("t1_type",   32'(cmd_type),   32'h01);
    chk("t1_length", 32'(cmd_length), 32'd2);
    tick();
    chk("t1_idle",   32'(frame_busy), 32'd0);

    // Same frame with checksum 34
    send_frame(8'h01, 2, 8'h07, -1, 0, 1'b1);
    chk("t2_error", 32'(cmd_error),  32'd1);
    chk("t2_code",  32'(error_code), 32'd1);
    chk("t2_done",  32'(cmd_done),   32'd0);
    tick();

    // AA 55 07 04 01: length 1025 over the limit
    send_frame(8'h07, 1025, 8'h00, -1, 0, 1'b1);
    chk("t3_error",  32'(cmd_error),  32'd1);
    chk("t3_code",   32'(error_code), 32'd2);
    chk("t3_start",  32'(cmd_start),  32'd0);
    chk("t3_length", 32'(cmd_length), 32'd2);
    fill_payload(3);
    send_frame(8'h11, 3, 8'h00, -1, 0, 1'b1);
    chk("t3_recover", 32'(cmd_done), 32'd1);

    // 00 AA AA 55 02 00 00 02: resync on double AA, zero-length frame
    put(8'h00, t);
    put(8'hAA, t);
    exp_busy(t, 1'b1);
    pl.delete();
    send_frame(8'h02, 0, 8'h00, -1, 0, 1'b1);
    chk("t4_done",   32'(cmd_done),   32'd1);
    chk("t4_length", 32'(cmd_length), 32'd0);
    chk("t4_type",   32'(cmd_type),   32'h02);

    // AA 55 01 00 03 10 then silence
    pl = '{8'h10, 8'h00, 8'h00};
    send_frame(8'h01, 3, 8'h00, 6, 0, 1'b1);
    chk("t5_code", 32'(error_code), 32'd3);
    chk("t5_busy", 32'(frame_busy), 32'd0);

    // Reset during payload, then a clean frame
    fill_payload(8);
    send_frame(8'h05, 8, 8'h00, 9, 0, 1'b0);
    tick();
    rst = 1'b1;
    evq.delete();
    #1;
    chk("t6_busy",   32'(frame_busy), 32'd0);
    chk("t6_length", 32'(cmd_length), 32'd0);
    chk("t6_code",   32'(error_code), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    fill_payload(4);
    send_frame(8'h06, 4, 8'h00, -1, 0, 1'b1);
    chk("t6_after", 32'(cmd_done), 32'd1);

    // Every byte lands exactly in the timeout expiry cycle
    fill_payload(3);
    send_frame(8'h09, 3, 8'h00, -1, -TOUT, 1'b1);
    chk("t7_done", 32'(cmd_done), 32'd1);

    // Largest accepted length
    fill_payload(MAXP);
    send_frame(8'h0A, MAXP, 8'h00, -1, 0, 1'b1);
    chk("t8_done",   32'(cmd_done),   32'd1);
    chk("t8_length", 32'(cmd_length), 32'(MAXP));

    // Randomized traffic
    for (int k = 0; k < 200; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 8) begin
        do x = 8'($urandom); while (x == 8'hAA);
        put(x, t);
      end else if (r < 16) begin
        put(8'hAA, t);
        exp_busy(t, 1'b1);
        idle(pick_gap(TOUT) - 1);
        do x = 8'($urandom); while (x == 8'hAA || x == 8'h55);
        put(x, t);
        exp_busy(t, 1'b0);
      end else if (r < 22) begin
        send_frame(8'($urandom), int'($urandom_range(MAXP + 1, 65535)), 8'h00, -1, 0, 1'b1);
      end else begin
        len   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 60)) : int'($urandom_range(0, 6));
        xr    = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
        trunc = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 5 + len)) : -1;
        gm    = ($urandom_range(0, 2) == 0) ? TOUT : 0;
        if ($urandom_range(0, 9) == 0) begin
          put(8'hAA, t);
          exp_busy(t, 1'b1);
        end
        fill_payload(len);
        send_frame(8'($urandom), len, xr, trunc, gm, 1'b1);
      end
      idle(int'($urandom_range(0, 3)));
    end

    idle(3);
    chk("pending_expectations", 32'(evq.num()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    n_bad++;
    $display("FAIL watchdog: bench did not complete, edge %0d", ecnt);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
